// File: rtl/keccak_io_sequencer.sv
// Host-side sequencer for the Keccak state file: loads/absorbs rate lanes, kicks the
// round controller, waits for done and streams digest lanes out, arbitrating file ownership.
module keccak_io_sequencer #(
  parameter int LANES     = 25,
  parameter int LANE_W    = 64,
  parameter int IN_LANES  = 17,
  parameter int OUT_LANES = 4,
  parameter int WAIT_MAX  = 4096
) (
  input  logic              clock_i,
  input  logic              reset_n_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [1:0]        cmd_op_i,
  input  logic              cmd_out_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [LANE_W-1:0] in_lane_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [LANE_W-1:0] out_lane_o,
  output logic              out_last_o,
  output logic [4:0]        file_addr_o,
  output logic [LANE_W-1:0] file_wdata_o,
  output logic              file_wr_o,
  input  logic [LANE_W-1:0] file_rdata_i,
  output logic              core_own_o,
  output logic              core_start_o,
  input  logic              core_done_i,
  output logic              busy_o,
  output logic              err_timeout_o
);

  localparam int CNT_W = $clog2(WAIT_MAX + 1);
  localparam logic [4:0]       IN_LAST   = 5'(IN_LANES - 1);
  localparam logic [4:0]       OUT_LAST  = 5'(OUT_LANES - 1);
  localparam logic [4:0]       LANE_LAST = 5'(LANES - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_MAX - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CLEAR,
    S_KICK,
    S_WAIT,
    S_UNLOAD
  } state_e;

  state_e           state_q, state_d;
  logic [4:0]       idx_q, idx_d;
  logic [CNT_W-1:0] wait_q, wait_d;
  logic             absorb_q, absorb_d;
  logic             out_q, out_d;
  logic             err_q, err_d;
  logic             ready_q, ready_d;

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      wait_q   <= '0;
      absorb_q <= 1'b0;
      out_q    <= 1'b0;
      err_q    <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      wait_q   <= wait_d;
      absorb_q <= absorb_d;
      out_q    <= out_d;
      err_q    <= err_d;
      ready_q  <= ready_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    wait_d       = wait_q;
    absorb_d     = absorb_q;
    out_d        = out_q;
    err_d        = err_q;
    in_ready_o   = 1'b0;
    out_valid_o  = 1'b0;
    out_lane_o   = '0;
    out_last_o   = 1'b0;
    file_addr_o  = '0;
    file_wdata_o = '0;
    file_wr_o    = 1'b0;
    core_own_o   = 1'b0;
    core_start_o = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid_i && ready_q) begin
          absorb_d = (cmd_op_i == 2'b01);
          out_d    = cmd_out_i;
          idx_d    = '0;
          unique case (cmd_op_i)
            2'b10:   state_d = S_UNLOAD;
            2'b11:   state_d = S_CLEAR;
            default: state_d = S_LOAD;
          endcase
        end
      end
      S_LOAD: begin
        file_addr_o = idx_q;
        in_ready_o  = 1'b1;
        if (in_valid_i) begin
          file_wr_o    = 1'b1;
          file_wdata_o = absorb_q ? (in_lane_i ^ file_rdata_i) : in_lane_i;
          if (idx_q == IN_LAST) begin
            idx_d   = '0;
            state_d = S_KICK;
          end else begin
            idx_d = idx_q + 5'd1;
          end
        end
      end
      S_CLEAR: begin
        file_addr_o = idx_q;
        file_wr_o   = 1'b1;
        if (idx_q == LANE_LAST) begin
          idx_d   = '0;
          state_d = S_IDLE;
        end else begin
          idx_d = idx_q + 5'd1;
        end
      end
      S_KICK: begin
        core_start_o = 1'b1;
        core_own_o   = 1'b1;
        wait_d       = '0;
        state_d      = S_WAIT;
      end
      S_WAIT: begin
        // done is checked before the limit so a same-cycle done is not flagged as timeout
        core_own_o = 1'b1;
        if (core_done_i) begin
          idx_d   = '0;
          state_d = out_q ? S_UNLOAD : S_IDLE;
        end else if (wait_q == WAIT_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          wait_d = wait_q + CNT_W'(1);
        end
      end
      S_UNLOAD: begin
        file_addr_o = idx_q;
        out_valid_o = 1'b1;
        out_lane_o  = file_rdata_i;
        out_last_o  = (idx_q == OUT_LAST);
        if (out_ready_i) begin
          if (idx_q == OUT_LAST) begin
            idx_d   = '0;
            state_d = S_IDLE;
          end else begin
            idx_d = idx_q + 5'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Registered so cmd_ready reads 0 while reset is held and rises one edge after release.
  assign ready_d       = (state_d == S_IDLE);
  assign cmd_ready_o   = ready_q;
  assign busy_o        = (state_q != S_IDLE);
  assign err_timeout_o = err_q;

endmodule

// File: tb/tb_keccak_io_sequencer.sv
// Scoreboard bench for keccak_io_sequencer: a file model, a stub round controller,
// and a negedge monitor comparing writes and output transfers against queued expectations.
module tb_keccak_io_sequencer;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_op;
  logic        cmd_out;
  logic        in_valid, in_ready;
  logic [63:0] in_lane;
  logic        out_valid, out_ready;
  logic [63:0] out_lane;
  logic        out_last;
  logic [4:0]  file_addr;
  logic [63:0] file_wdata;
  logic        file_wr;
  logic [63:0] file_rdata;
  logic        core_own, core_start, core_done;
  logic        busy, err_timeout;

  keccak_io_sequencer #(
    .LANES(25), .LANE_W(64), .IN_LANES(17), .OUT_LANES(4), .WAIT_MAX(16)
  ) dut (
    .clock_i(clk), .reset_n_i(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_op_i(cmd_op), .cmd_out_i(cmd_out),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_lane_i(in_lane),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_lane_o(out_lane), .out_last_o(out_last),
    .file_addr_o(file_addr), .file_wdata_o(file_wdata), .file_wr_o(file_wr), .file_rdata_i(file_rdata),
    .core_own_o(core_own), .core_start_o(core_start), .core_done_i(core_done),
    .busy_o(busy), .err_timeout_o(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // State file model with combinational read.
  logic [63:0] mem [0:31];
  assign file_rdata = mem[file_addr];
  always @(posedge clk) if (file_wr) mem[file_addr] <= file_wdata;

  // Round controller stub: identity permutation, done three cycles after start unless hung.
  int core_cnt;
  int core_starts;
  bit core_hang;
  initial begin
    core_cnt    = 0;
    core_starts = 0;
  end
  always @(posedge clk) begin
    if (!rst_n) begin
      core_done <= 1'b0;
      core_cnt  <= 0;
    end else if (core_start) begin
      core_done   <= 1'b0;
      core_cnt    <= 3;
      core_starts <= core_starts + 1;
    end else if (core_cnt > 0) begin
      core_cnt <= core_cnt - 1;
      if (core_cnt == 1 && !core_hang) core_done <= 1'b1;
    end
  end

  typedef struct packed {logic [4:0] addr; logic [63:0] data;} wr_t;
  typedef struct packed {logic [63:0] lane; logic last;} out_t;
  wr_t  exp_wr[$];
  out_t exp_out[$];
  wr_t  mon_wr;
  out_t mon_out;

  int n_pass, n_total, n_xfer;
  logic [63:0] lanes_buf [0:16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  task automatic push_wr(input int a, input logic [63:0] d);
    wr_t e;
    e.addr = 5'(a);
    e.data = d;
    exp_wr.push_back(e);
  endtask

  task automatic push_out(input logic [63:0] l, input logic last);
    out_t e;
    e.lane = l;
    e.last = last;
    exp_out.push_back(e);
  endtask

  // Monitor: samples on the falling edge, decoupled from stimulus.
  initial begin
    n_pass  = 0;
    n_total = 0;
    n_xfer  = 0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (file_wr) begin
          check("own_during_wr", 64'(core_own), 64'd0);
          if (exp_wr.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_wr: got addr %0d data 0x%0h, required no write", file_addr, file_wdata);
          end else begin
            mon_wr = exp_wr.pop_front();
            check("wr_addr", 64'(file_addr), 64'(mon_wr.addr));
            check("wr_data", file_wdata, mon_wr.data);
            $display("wr addr=%0d data=0x%0h", file_addr, file_wdata);
          end
        end
        if (out_valid && exp_out.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_out: got lane 0x%0h, required no out_valid", out_lane);
        end else if (out_valid && out_ready) begin
          mon_out = exp_out.pop_front();
          n_xfer++;
          check("out_lane", out_lane, mon_out.lane);
          check("out_last", 64'(out_last), 64'(mon_out.last));
          $display("out lane=0x%0h last=%0d", out_lane, out_last);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic o);
    int n = 0;
    cmd_op    = op;
    cmd_out   = o;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 20) begin
      tick();
      n++;
    end
    if (!cmd_ready) begin
      n_total++;
      $display("FAIL cmd_handshake: cmd_ready 0, required 1");
    end
    tick();
    cmd_valid = 1'b0;
    $display("cmd op=%0d out=%0d issued", op, o);
  endtask

  task automatic feed(input int n);
    in_valid = 1'b1;
    for (int i = 0; i < n; i++) begin
      in_lane = lanes_buf[i];
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while (busy && n < max) begin
      tick();
      n++;
    end
    if (busy) begin
      n_total++;
      $display("FAIL wait_idle: busy 1 after %0d cycles, required 0", max);
    end
  endtask

  int base_xfer, base_starts, nw;

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_out = 1'b0;
    in_valid = 1'b0; in_lane = '0; out_ready = 1'b0; core_hang = 1'b0;
    repeat (3) tick();
    check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_err", 64'(err_timeout), 64'd0);
    check("rst_strobes", 64'({in_ready, out_valid, out_last, file_wr, core_start, core_own}), 64'd0);
    check("rst_addr", 64'(file_addr), 64'd0);
    check("rst_wdata", file_wdata, 64'd0);
    check("rst_out_lane", out_lane, 64'd0);
    rst_n = 1'b1;
    tick();
    check("cmd_ready_after_rst", 64'(cmd_ready), 64'd1);

    // LOAD, no output
    for (int i = 0; i < 17; i++) begin
      lanes_buf[i] = 64'(i + 1);
      push_wr(i, 64'(i + 1));
    end
    issue(2'b00, 1'b0);
    check("t1_in_ready", 64'(in_ready), 64'd1);
    feed(17);
    check("t1_core_start", 64'(core_start), 64'd1);
    check("t1_own_kick", 64'(core_own), 64'd1);
    tick();
    check("t1_start_pulse", 64'(core_start), 64'd0);
    check("t1_own_wait", 64'(core_own), 64'd1);
    wait_idle(100);
    check("t1_own_idle", 64'(core_own), 64'd0);
    check("t1_starts", 64'(core_starts), 64'd1);

    // LOAD preset: lane 3 = 0xFF00, others 0xA000+i
    for (int i = 0; i < 17; i++) begin
      lanes_buf[i] = (i == 3) ? 64'hFF00 : 64'hA000 + 64'(i);
      push_wr(i, lanes_buf[i]);
    end
    issue(2'b00, 1'b0);
    feed(17);
    wait_idle(100);

    // ABSORB with output and backpressure on lane 1
    for (int i = 0; i < 17; i++) begin
      nw = i;
      push_wr(i, (i == 3) ? 64'hF00F : ((64'hA000 + 64'(i)) ^ (64'h0101 * 64'(nw))));
      lanes_buf[i] = (i == 3) ? 64'h0F0F : 64'h0101 * 64'(nw);
    end
    push_out(64'hA000, 1'b0);
    push_out(64'hA100, 1'b0);
    push_out(64'hA200, 1'b0);
    push_out(64'hF00F, 1'b1);
    base_xfer = n_xfer;
    out_ready = 1'b1;
    issue(2'b01, 1'b1);
    feed(17);
    nw = 0;
    while (!out_valid && nw < 50) begin
      tick();
      nw++;
    end
    check("t3_out_valid", 64'(out_valid), 64'd1);
    tick();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("bp_valid", 64'(out_valid), 64'd1);
      check("bp_lane", out_lane, 64'hA100);
      check("bp_last", 64'(out_last), 64'd0);
      tick();
    end
    out_ready = 1'b1;
    wait_idle(50);
    check("t3_xfers", 64'(n_xfer - base_xfer), 64'd4);

    // Timeout
    core_hang = 1'b1;
    for (int i = 0; i < 17; i++) begin
      lanes_buf[i] = 64'h20 + 64'(i);
      push_wr(i, lanes_buf[i]);
    end
    issue(2'b00, 1'b1);
    feed(17);
    check("t4_kick", 64'(core_start), 64'd1);
    for (int k = 1; k <= 16; k++) tick();
    check("t4_busy_16", 64'(busy), 64'd1);
    check("t4_err_16", 64'(err_timeout), 64'd0);
    tick();
    check("t4_err", 64'(err_timeout), 64'd1);
    check("t4_idle", 64'(busy), 64'd0);
    check("t4_own", 64'(core_own), 64'd0);
    core_hang = 1'b0;

    // CLEAR then SQUEEZE
    for (int i = 0; i < 25; i++) push_wr(i, 64'd0);
    issue(2'b11, 1'b0);
    repeat (24) tick();
    check("t5_busy_24", 64'(busy), 64'd1);
    tick();
    check("t5_idle_25", 64'(busy), 64'd0);
    check("t5_err_sticky", 64'(err_timeout), 64'd1);
    base_starts = core_starts;
    base_xfer   = n_xfer;
    for (int i = 0; i < 4; i++) push_out(64'd0, (i == 3));
    issue(2'b10, 1'b0);
    wait_idle(50);
    check("t5_no_start", 64'(core_starts), 64'(base_starts));
    check("t5_xfers", 64'(n_xfer - base_xfer), 64'd4);

    // Reset mid-LOAD
    for (int i = 0; i < 17; i++) lanes_buf[i] = 64'h30 + 64'(i);
    for (int i = 0; i < 6; i++) push_wr(i, lanes_buf[i]);
    issue(2'b00, 1'b0);
    feed(6);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_err", 64'(err_timeout), 64'd0);
    check("mid_rst_cmd_ready", 64'(cmd_ready), 64'd0);
    check("mid_rst_strobes", 64'({in_ready, out_valid, out_last, file_wr, core_start, core_own}), 64'd0);
    check("mid_rst_addr", 64'(file_addr), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 17; i++) begin
      lanes_buf[i] = 64'h40 + 64'(i);
      push_wr(i, lanes_buf[i]);
    end
    issue(2'b00, 1'b0);
    feed(17);
    wait_idle(100);

    check("exp_wr_left", 64'(exp_wr.size()), 64'd0);
    check("exp_out_left", 64'(exp_out.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1, "watchdog expired");
  end

endmodule
